// File: rtl/idma_rd_arbiter.sv
// -----------------------------------------------------------------------------
// idma_rd_arbiter
//
// Shares one iDMA read channel between two read requesters. One read is in
// flight at a time. Arbitration is round-robin between the two requesters.
// The granted address and word count are registered and presented to the DMA.
// Returned beats are steered only to the granted requester. The channel is
// released after the final beat.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   sN_rd_req/addr/num              requester N read request (held until ready)
//   sN_rd_addr_ready                requester N request accepted (1-cycle pulse)
//   sN_rd_data_valid/ready/last     requester N beat handshake and last flag
//   s_rd_data                       beat data shared by both requesters
//   m_rd_req/addr/num/addr_ready    DMA request channel
//   m_rd_data_valid/data/ready      DMA beat channel
//   busy                            a read is in progress
//   grant_id                        current or most recent granted requester
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | channel free; a pending request is granted combinationally
// ADDR  | m_rd_req held with the latched address/count until DMA accepts
// DATA  | beats are forwarded to the granted requester until the last one
// -----------------------------------------------------------------------------
module idma_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_W      = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s0_rd_req,
    input  logic [ADDR_WIDTH-1:0] s0_rd_addr,
    input  logic [31:0]           s0_rd_num,
    output logic                  s0_rd_addr_ready,
    output logic                  s0_rd_data_valid,
    input  logic                  s0_rd_data_ready,
    output logic                  s0_rd_data_last,

    input  logic                  s1_rd_req,
    input  logic [ADDR_WIDTH-1:0] s1_rd_addr,
    input  logic [31:0]           s1_rd_num,
    output logic                  s1_rd_addr_ready,
    output logic                  s1_rd_data_valid,
    input  logic                  s1_rd_data_ready,
    output logic                  s1_rd_data_last,

    output logic [DATA_WIDTH-1:0] s_rd_data,

    output logic                  m_rd_req,
    output logic [ADDR_WIDTH-1:0] m_rd_addr,
    output logic [31:0]           m_rd_num,
    input  logic                  m_rd_addr_ready,
    input  logic                  m_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] m_rd_data,
    output logic                  m_rd_data_ready,

    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_grant_id;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [CNT_W-1:0]      r_beats;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_num;

    logic                  w_grant_any;
    logic                  w_grant_sel;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]           w_sel_num;
    logic                  w_in_data;
    logic                  w_g_ready;
    logic                  w_data_hs;
    logic                  w_last_beat;

    // With both requesting, the one that did not win last time goes next.
    assign w_grant_any = s0_rd_req | s1_rd_req;
    assign w_grant_sel = (s0_rd_req && s1_rd_req) ? ~r_last_grant : s1_rd_req;
    assign w_grant     = (r_state == IDLE) && w_grant_any;
    assign w_sel_addr  = w_grant_sel ? s1_rd_addr : s0_rd_addr;
    assign w_sel_num   = w_grant_sel ? s1_rd_num  : s0_rd_num;

    assign w_in_data   = (r_state == DATA);
    assign w_g_ready   = r_grant_id ? s1_rd_data_ready : s0_rd_data_ready;
    assign w_data_hs   = w_in_data && m_rd_data_valid && w_g_ready;
    // Only meaningful in DATA, where r_beats is known to be non-zero.
    assign w_last_beat = (r_beat_cnt == (r_beats - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_beat_cnt   <= '0;
            r_beats      <= '0;
            r_addr       <= '0;
            r_num        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_addr     <= w_sel_addr;
                        r_num      <= w_sel_num;
                        r_beats    <= w_sel_num[CNT_W+2:3];
                        r_grant_id <= w_grant_sel;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_rd_addr_ready) begin
                        r_beat_cnt <= '0;
                        if (r_beats == '0) begin
                            // Zero-length read: nothing to return, free the channel.
                            r_last_grant <= r_grant_id;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_data_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt   <= '0;
                            r_last_grant <= r_grant_id;
                            r_state      <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s0_rd_addr_ready = w_grant && !w_grant_sel;
    assign s1_rd_addr_ready = w_grant &&  w_grant_sel;

    assign m_rd_req         = (r_state == ADDR);
    assign m_rd_addr        = r_addr;
    assign m_rd_num         = r_num;

    // Outside DATA the DMA is held off, so early beats wait rather than drop.
    assign m_rd_data_ready  = w_in_data && w_g_ready;

    assign s0_rd_data_valid = w_in_data && !r_grant_id && m_rd_data_valid;
    assign s1_rd_data_valid = w_in_data &&  r_grant_id && m_rd_data_valid;
    assign s0_rd_data_last  = s0_rd_data_valid && w_last_beat;
    assign s1_rd_data_last  = s1_rd_data_valid && w_last_beat;
    assign s_rd_data        = m_rd_data;

    assign busy             = (r_state != IDLE);
    assign grant_id         = r_grant_id;

endmodule

// File: tb/tb_idma_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_idma_rd_arbiter
//
// Random traffic from two requesters and a DMA model. Each request is queued
// when it is raised. A monitor process tracks channel ownership from the
// arbitration rules and pops the queued request when the grant is seen. It
// then checks the DMA request, beat routing, data content and last flags.
// -----------------------------------------------------------------------------
module tb_idma_rd_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int CNT_W = 13;

    localparam int M_IDLE = 0;
    localparam int M_ADDR = 1;
    localparam int M_DATA = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] num;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]    req;
    logic [31:0]   raddr [2];
    logic [31:0]   rnum  [2];
    logic [1:0]    dready;

    logic          s0_rd_addr_ready, s1_rd_addr_ready;
    logic          s0_rd_data_valid, s1_rd_data_valid;
    logic          s0_rd_data_last,  s1_rd_data_last;
    logic [DW-1:0] s_rd_data;
    logic          m_rd_req;
    logic [AW-1:0] m_rd_addr;
    logic [31:0]   m_rd_num;
    logic          m_rd_addr_ready;
    logic          m_rd_data_valid;
    logic [DW-1:0] m_rd_data;
    logic          m_rd_data_ready;
    logic          busy;
    logic          grant_id;

    logic [1:0] ardy, dvalid, dlast;
    assign ardy   = {s1_rd_addr_ready, s0_rd_addr_ready};
    assign dvalid = {s1_rd_data_valid, s0_rd_data_valid};
    assign dlast  = {s1_rd_data_last,  s0_rd_data_last};

    idma_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s0_rd_req        (req[0]),
        .s0_rd_addr       (raddr[0]),
        .s0_rd_num        (rnum[0]),
        .s0_rd_addr_ready (s0_rd_addr_ready),
        .s0_rd_data_valid (s0_rd_data_valid),
        .s0_rd_data_ready (dready[0]),
        .s0_rd_data_last  (s0_rd_data_last),
        .s1_rd_req        (req[1]),
        .s1_rd_addr       (raddr[1]),
        .s1_rd_num        (rnum[1]),
        .s1_rd_addr_ready (s1_rd_addr_ready),
        .s1_rd_data_valid (s1_rd_data_valid),
        .s1_rd_data_ready (dready[1]),
        .s1_rd_data_last  (s1_rd_data_last),
        .s_rd_data        (s_rd_data),
        .m_rd_req         (m_rd_req),
        .m_rd_addr        (m_rd_addr),
        .m_rd_num         (m_rd_num),
        .m_rd_addr_ready  (m_rd_addr_ready),
        .m_rd_data_valid  (m_rd_data_valid),
        .m_rd_data        (m_rd_data),
        .m_rd_data_ready  (m_rd_data_ready),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    int errors = 0;
    int checks = 0;

    int req_pct, ardy_pct, dvalid_pct, dready_pct;

    // Requests raised but not yet granted, one queue per requester.
    req_t rq0 [$];
    req_t rq1 [$];

    // DMA side: bursts accepted by the DMA and the beat index within the head.
    logic [31:0]      dq_addr  [$];
    logic [CNT_W-1:0] dq_beats [$];
    int               d_idx;

    // Reference model of channel ownership.
    int               ms;
    logic             m_last;
    logic             m_g;
    logic [31:0]      m_addr;
    logic [31:0]      m_num;
    int               m_beats;
    int               m_cnt;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gen(input logic [31:0] a, input int i);
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++)
            r[k*32 +: 32] = a ^ (32'(i) * 32'h9E3779B9) ^ (32'(k) * 32'h01010101);
        return r;
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // Requesters and DMA model: sample on the falling edge, drive after rising.
    initial begin : drv
        logic [1:0]  acc;
        logic [31:0] num;
        req_t        r;
        req       = '0;
        dready    = '0;
        raddr[0]  = '0; raddr[1] = '0;
        rnum[0]   = '0; rnum[1]  = '0;
        m_rd_addr_ready = 1'b0;
        m_rd_data_valid = 1'b0;
        m_rd_data       = '0;
        d_idx     = 0;
        acc       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dq_addr.delete();
                dq_beats.delete();
                rq0.delete();
                rq1.delete();
                d_idx = 0;
                acc   = '0;
            end else begin
                acc = ardy;
                if (m_rd_req && m_rd_addr_ready && (m_rd_num[CNT_W+2:3] != '0)) begin
                    dq_addr.push_back(m_rd_addr);
                    dq_beats.push_back(m_rd_num[CNT_W+2:3]);
                end
                if (m_rd_data_valid && m_rd_data_ready && dq_beats.size() > 0) begin
                    d_idx++;
                    if (d_idx == int'(dq_beats[0])) begin
                        void'(dq_addr.pop_front());
                        void'(dq_beats.pop_front());
                        d_idx = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (!rst_n || acc[n]) begin
                    req[n] = 1'b0;
                end else if (!req[n] && roll(req_pct)) begin
                    num = 32'($urandom_range(5)) * 32'd8;
                    if (roll(25)) num = num | 32'($urandom_range(7));
                    if (roll(25)) num = num | 32'h0010_0000;
                    raddr[n] = $urandom() & 32'hFFFF_FFE0;
                    rnum[n]  = num;
                    req[n]   = 1'b1;
                    r.addr   = raddr[n];
                    r.num    = num;
                    if (n == 0) rq0.push_back(r);
                    else        rq1.push_back(r);
                end
                dready[n] = roll(dready_pct);
            end
            m_rd_addr_ready = rst_n && roll(ardy_pct);
            if (rst_n && dq_beats.size() > 0 && roll(dvalid_pct)) begin
                m_rd_data_valid = 1'b1;
                m_rd_data       = gen(dq_addr[0], d_idx);
            end else begin
                m_rd_data_valid = 1'b0;
                m_rd_data       = {8{$urandom()}};
            end
        end
    end

    // Monitor: compares DUT outputs against the ownership model every cycle.
    initial begin : mon
        int   nxt;
        logic eg, eg_any, g, hs;
        req_t r;
        ms     = M_IDLE;
        m_last = 1'b1;
        m_g    = 1'b0;
        m_addr = '0;
        m_num  = '0;
        m_beats = 0;
        m_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_m_rd_req",   m_rd_req, 0);
                chk("rst_m_rd_ready", m_rd_data_ready, 0);
                chk("rst_valid",      dvalid, 0);
                chk("rst_last",       dlast, 0);
                chk("rst_busy",       busy, 0);
                chk("rst_m_rd_addr",  m_rd_addr, 0);
                chk("rst_m_rd_num",   m_rd_num, 0);
                ms     = M_IDLE;
                m_last = 1'b1;
                m_cnt  = 0;
            end else begin
                nxt = ms;
                g   = m_g;
                chk("m_rd_req", m_rd_req, ms == M_ADDR);
                chk("busy", busy, ms != M_IDLE);
                if (ms != M_IDLE) chk("grant_id", grant_id, m_g);

                if (ms == M_ADDR) begin
                    chk("m_rd_addr", m_rd_addr, m_addr);
                    chk("m_rd_num", m_rd_num, m_num);
                    if (m_rd_addr_ready) begin
                        if (m_beats == 0) begin
                            nxt    = M_IDLE;
                            m_last = m_g;
                        end else begin
                            nxt   = M_DATA;
                            m_cnt = 0;
                        end
                    end
                end

                if (ms == M_DATA) begin
                    chk("valid_granted", dvalid[g], m_rd_data_valid);
                    chk("valid_other", dvalid[g ^ 1'b1], 0);
                    chk("m_rd_data_ready", m_rd_data_ready, dready[g]);
                    chk("s_rd_data_pass", s_rd_data, m_rd_data);
                    chk("last_granted", dlast[g], m_rd_data_valid && (m_cnt == m_beats - 1));
                    chk("last_other", dlast[g ^ 1'b1], 0);
                    hs = m_rd_data_valid && dready[g];
                    if (hs) begin
                        chk("beat_data", s_rd_data, gen(m_addr, m_cnt));
                        m_cnt++;
                        if (m_cnt == m_beats) begin
                            nxt    = M_IDLE;
                            m_last = m_g;
                            m_cnt  = 0;
                        end
                    end
                end else begin
                    chk("m_rd_data_ready_gated", m_rd_data_ready, 0);
                    chk("valid_gated", dvalid, 0);
                    chk("last_gated", dlast, 0);
                end

                if (ms == M_IDLE) begin
                    eg_any = req[0] | req[1];
                    eg     = (req[0] && req[1]) ? ~m_last : req[1];
                    chk("addr_ready0", ardy[0], eg_any && !eg);
                    chk("addr_ready1", ardy[1], eg_any && eg);
                    if (eg_any) begin
                        if ((eg ? rq1.size() : rq0.size()) == 0) begin
                            chk("grant_has_request", 0, 1);
                        end else begin
                            r = eg ? rq1.pop_front() : rq0.pop_front();
                            m_addr  = r.addr;
                            m_num   = r.num;
                            m_beats = int'(r.num[CNT_W+2:3]);
                            m_g     = eg;
                            nxt     = M_ADDR;
                        end
                    end
                end else begin
                    chk("addr_ready_outside_idle", ardy, 0);
                end
                ms = nxt;
            end
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(posedge clk);
    endtask

    task automatic knobs(input int rq, input int ar, input int dv, input int dr);
        req_pct = rq; ardy_pct = ar; dvalid_pct = dv; dready_pct = dr;
    endtask

    initial begin : main
        bit hit;
        rst_n = 1'b0;
        knobs(0, 100, 100, 100);
        run(3);
        #2 rst_n = 1'b1;

        // Continuous dual requests: grants must alternate starting with s0.
        knobs(100, 100, 100, 100);
        run(80);

        // Mixed random traffic with back-pressure on both sides.
        knobs(30, 60, 70, 50);
        run(1500);

        // Frequent DMA address stalls.
        knobs(40, 10, 60, 60);
        run(400);

        // Reset in the middle of a data phase.
        knobs(50, 80, 30, 40);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (ms == M_DATA && m_cnt >= 1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_mid_data", hit, 1);
        #2 rst_n = 1'b0;
        run(2);
        #2 rst_n = 1'b1;

        knobs(35, 70, 70, 60);
        run(800);

        // Stop new requests and let everything drain.
        knobs(0, 100, 100, 100);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (ms == M_IDLE && req == 2'b00 && rq0.size() == 0 && rq1.size() == 0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("drain_idle", hit, 1);
        run(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
